// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit
//   Pipeline sequencer for the IF/ID register and the front end. It detects load-use
//   hazards, taken-branch flushes and data-memory wait states. It drives PC write-enable,
//   IF/ID write/clear, the ID/EX bubble and a global hold. It also keeps saturating
//   stall/flush counters for performance debug.
// Ports
//   clk, clear_n          rising-edge clock, asynchronous active-low reset
//   rs1_id/rs2_id         source indices of the ID instruction, with rs1_used/rs2_used
//   ex_mem_read, ex_rd    EX instruction is a load, and its destination index
//   branch_taken          EX resolved a taken branch/jump this cycle
//   mem_busy              data memory not ready, so the whole pipe freezes
//   pc_write ..pipe_hold  same-cycle pipeline control outputs
//   stall_count           cycles lost to load-use bubbles and memory waits
//   flush_count           taken-branch flush events
module hazard_ctrl_unit #(
   parameter int unsigned REG_ADDR_W   = 5,
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned CNT_W        = 16
) (
   input  logic                  clk,
   input  logic                  clear_n,
   input  logic [REG_ADDR_W-1:0] rs1_id,
   input  logic [REG_ADDR_W-1:0] rs2_id,
   input  logic                  rs1_used,
   input  logic                  rs2_used,
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  branch_taken,
   input  logic                  mem_busy,
   output logic                  pc_write,
   output logic                  if_id_write,
   output logic                  if_id_clear,
   output logic                  id_ex_bubble,
   output logic                  pipe_hold,
   output logic [CNT_W-1:0]      stall_count,
   output logic [CNT_W-1:0]      flush_count
);

   localparam int unsigned FcntW = $clog2(FLUSH_CYCLES + 1);
   localparam logic [FcntW-1:0] FcntLoad = FcntW'(FLUSH_CYCLES);
   localparam logic [FcntW-1:0] FcntOne  = FcntW'(1);

   typedef enum logic [1:0] {StRun, StFlush, StMemWait} state_e;

   state_e            state_q, state_d;
   state_e            ret_st_q, ret_st_d;
   state_e            eff_st;
   logic [FcntW-1:0]  fcnt_q, fcnt_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
   logic              load_use;
   logic              stall_inc;
   logic              flush_inc;

   assign load_use = ex_mem_read && (ex_rd != '0) &&
                     ((rs1_used && (rs1_id == ex_rd)) || (rs2_used && (rs2_id == ex_rd)));

   // After a memory wait, the saved state's rules apply in the release cycle itself.
   assign eff_st = (state_q == StMemWait) ? ret_st_q : state_q;

   always_comb begin
      state_d      = state_q;
      ret_st_d     = ret_st_q;
      fcnt_d       = fcnt_q;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_clear  = 1'b0;
      id_ex_bubble = 1'b0;
      pipe_hold    = 1'b0;

      if (mem_busy) begin
         // Freeze: branch and load-use are ignored, and fcnt holds.
         pipe_hold = 1'b1;
         stall_inc = 1'b1;
         if (state_q != StMemWait) begin
            ret_st_d = state_q;
            state_d  = StMemWait;
         end
      end else begin
         unique case (eff_st)
            StFlush: begin
               pc_write     = 1'b1;
               if_id_clear  = 1'b1;
               id_ex_bubble = 1'b1;
               if (branch_taken) begin
                  fcnt_d    = FcntLoad;
                  flush_inc = 1'b1;
                  state_d   = StFlush;
               end else begin
                  fcnt_d  = fcnt_q - FcntOne;
                  state_d = (fcnt_q == FcntOne) ? StRun : StFlush;
               end
            end
            default: begin
               state_d = StRun;
               if (branch_taken) begin
                  pc_write     = 1'b1;
                  if_id_clear  = 1'b1;
                  id_ex_bubble = 1'b1;
                  flush_inc    = 1'b1;
                  fcnt_d       = FcntLoad;
                  state_d      = StFlush;
               end else if (load_use) begin
                  id_ex_bubble = 1'b1;
                  stall_inc    = 1'b1;
               end else begin
                  pc_write    = 1'b1;
                  if_id_write = 1'b1;
               end
            end
         endcase
      end

      stall_cnt_d = (stall_inc && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
      flush_cnt_d = (flush_inc && (flush_cnt_q != '1)) ? flush_cnt_q + 1'b1 : flush_cnt_q;

      // While reset is held, park the front end with a NOP in IF/ID and a bubble in ID/EX.
      if (!clear_n) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         if_id_clear  = 1'b1;
         id_ex_bubble = 1'b1;
         pipe_hold    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state_q     <= StRun;
         ret_st_q    <= StRun;
         fcnt_q      <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         ret_st_q    <= ret_st_d;
         fcnt_q      <= fcnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_count = stall_cnt_q;
   assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit
//   Directed scenarios followed by random stimulus. Everything is checked against a
//   behavioural model that tracks only "flush cycles still owed" and two saturating
//   integer counters.
module tb_hazard_ctrl_unit;

   localparam int unsigned RegW   = 5;
   localparam int unsigned FlushN = 2;
   localparam int unsigned CntW   = 6;
   localparam int          CntMax = (1 << CntW) - 1;

   logic            clk = 1'b0;
   logic            clear_n;
   logic [RegW-1:0] rs1_id, rs2_id, ex_rd;
   logic            rs1_used, rs2_used, ex_mem_read, branch_taken, mem_busy;
   logic            pc_write, if_id_write, if_id_clear, id_ex_bubble, pipe_hold;
   logic [CntW-1:0] stall_count, flush_count;

   int checks   = 0;
   int failures = 0;

   // Model state.
   int m_stall      = 0;
   int m_flush      = 0;
   int m_flush_left = 0;

   always #5 clk = ~clk;

   hazard_ctrl_unit #(
      .REG_ADDR_W   (RegW),
      .FLUSH_CYCLES (FlushN),
      .CNT_W        (CntW)
   ) dut (
      .clk          (clk),
      .clear_n      (clear_n),
      .rs1_id       (rs1_id),
      .rs2_id       (rs2_id),
      .rs1_used     (rs1_used),
      .rs2_used     (rs2_used),
      .ex_mem_read  (ex_mem_read),
      .ex_rd        (ex_rd),
      .branch_taken (branch_taken),
      .mem_busy     (mem_busy),
      .pc_write     (pc_write),
      .if_id_write  (if_id_write),
      .if_id_clear  (if_id_clear),
      .id_ex_bubble (id_ex_bubble),
      .pipe_hold    (pipe_hold),
      .stall_count  (stall_count),
      .flush_count  (flush_count)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Runs one clock cycle: drives inputs at the falling edge, checks, then advances the model.
   task automatic step(input logic rst_v, input logic [RegW-1:0] r1, input logic [RegW-1:0] r2,
                       input logic [RegW-1:0] rd, input logic u1, input logic u2,
                       input logic mr, input logic br, input logic mb);
      logic       lu;
      logic [4:0] exp_ctrl;
      @(negedge clk);
      clear_n      = rst_v;
      rs1_id       = r1;
      rs2_id       = r2;
      ex_rd        = rd;
      rs1_used     = u1;
      rs2_used     = u2;
      ex_mem_read  = mr;
      branch_taken = br;
      mem_busy     = mb;
      if (!rst_v) begin
         m_stall      = 0;
         m_flush      = 0;
         m_flush_left = 0;
      end
      #1;
      lu = mr && (rd != 0) && ((u1 && r1 == rd) || (u2 && r2 == rd));
      // Order: {pc_write, if_id_write, if_id_clear, id_ex_bubble, pipe_hold}
      if (!rst_v)                        exp_ctrl = 5'b00110;
      else if (mb)                       exp_ctrl = 5'b00001;
      else if (m_flush_left > 0 || br)   exp_ctrl = 5'b10110;
      else if (lu)                       exp_ctrl = 5'b00010;
      else                               exp_ctrl = 5'b11000;
      check_eq("ctrl", {27'b0, pc_write, if_id_write, if_id_clear, id_ex_bubble, pipe_hold},
               {27'b0, exp_ctrl});
      check_eq("stall_count", {26'b0, stall_count}, m_stall);
      check_eq("flush_count", {26'b0, flush_count}, m_flush);
      @(posedge clk);
      if (rst_v) begin
         if (mb) begin
            m_stall = (m_stall < CntMax) ? m_stall + 1 : CntMax;
         end else if (br) begin
            m_flush      = (m_flush < CntMax) ? m_flush + 1 : CntMax;
            m_flush_left = FlushN;
         end else if (m_flush_left > 0) begin
            m_flush_left--;
         end else if (lu) begin
            m_stall = (m_stall < CntMax) ? m_stall + 1 : CntMax;
         end
      end
   endtask

   task automatic idle();
      step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      clear_n      = 1'b0;
      rs1_id       = '0;
      rs2_id       = '0;
      ex_rd        = '0;
      rs1_used     = 1'b0;
      rs2_used     = 1'b0;
      ex_mem_read  = 1'b0;
      branch_taken = 1'b0;
      mem_busy     = 1'b0;

      step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle();

      // Load-use on rs1 gives one bubble.
      step(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      idle();
      #1 check_eq("t1_stall", {26'b0, stall_count}, 32'd1);

      // No hazard with ex_rd=0 or with rs1 unused; rs2 match still stalls.
      step(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 5'd1, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      idle();
      #1 check_eq("t2_stall", {26'b0, stall_count}, 32'd2);

      // Branch gives the branch cycle plus FlushN cycles of clear; load-use is ignored in flush.
      step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 5'd3, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      idle();
      idle();
      #1 check_eq("t3_flush", {26'b0, flush_count}, 32'd1);

      // Memory wait during the last flush cycle, then one flush cycle on release.
      step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle();
      repeat (4) step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle();
      idle();
      #1 check_eq("t4_stall", {26'b0, stall_count}, 32'd6);

      // Branch, mem_busy and load-use together: only the freeze takes effect.
      step(1'b1, 5'd4, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      idle();
      #1 check_eq("t5_flush", {26'b0, flush_count}, 32'd2);

      // Saturation of both counters.
      repeat (CntMax + 4) step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      repeat (CntMax + 4) step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      #1 check_eq("t6_stall_sat", {26'b0, stall_count}, CntMax);
      check_eq("t6_flush_sat", {26'b0, flush_count}, CntMax);

      // Reset in the middle of a flush leaves no residual flush behind.
      step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle();
      #1 check_eq("t6_reset_flush", {26'b0, flush_count}, 32'd0);

      // Random traffic with occasional resets, including resets during memory waits.
      for (int i = 0; i < 3000; i++) begin
         logic rv;
         rv = ($urandom_range(0, 59) != 0);
         step(rv, RegW'($urandom_range(0, 3)), RegW'($urandom_range(0, 3)),
              RegW'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 99) < 15), 1'($urandom_range(0, 99) < 20));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
